// File: rtl/alu_muldiv_pkg.sv
// Shared types and constants for the iterative MUL/DIVU/REMU sequencer.
package alu_muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REMU = 2'b10,
        OP_RSVD = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam int         ITERS   = 32;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle MUL (low word), DIVU and REMU built on the shared external ALU,
// using shift-add multiplication and restoring division, one bit per cycle.
module alu_muldiv_seq
    import alu_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] AluSrcA,
    output logic [WIDTH-1:0] AluSrcB,
    output logic [2:0]       AluControl,
    input  logic [WIDTH-1:0] AluResult
);

    state_t           state_q, state_d;
    op_t              op_q, op_d, op_in;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // acc: product accumulator (MUL) or partial remainder (DIV/REM).
    // a:   multiplicand shifting left (MUL) or dividend/quotient shifting left (DIV/REM).
    // b:   multiplier shifting right (MUL) or the constant divisor (DIV/REM).
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] fin;
    logic             borrow;
    logic             sub;

    assign Busy   = (state_q == S_RUN);
    assign Done   = (state_q == S_DONE);
    assign Result = result_q;
    assign op_in  = op_t'(Op);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        a_d        = a_q;
        b_d        = b_q;
        result_d   = result_q;
        fin        = acc_q;
        AluSrcA    = '0;
        AluSrcB    = '0;
        AluControl = ALU_ADD;

        // Trial subtraction of the divisor from the shifted partial remainder.
        // hi is the bit shifted out of rem; when set, p+2^32 always exceeds
        // the divisor, so the subtraction is taken regardless of borrow.
        p      = {acc_q[WIDTH-2:0], a_q[WIDTH-1]};
        borrow = (~p[WIDTH-1] & b_q[WIDTH-1])
               | (~(p[WIDTH-1] ^ b_q[WIDTH-1]) & AluResult[WIDTH-1]);
        sub    = acc_q[WIDTH-1] | ~borrow;

        case (state_q)
            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q == OP_MUL) begin
                    AluSrcA    = acc_q;
                    AluSrcB    = a_q;
                    AluControl = ALU_ADD;
                    if (b_q[0]) acc_d = AluResult;
                    a_d = a_q << 1;
                    b_d = b_q >> 1;
                    fin = acc_d;
                end else begin
                    AluSrcA    = p;
                    AluSrcB    = b_q;
                    AluControl = ALU_SUB;
                    acc_d      = sub ? AluResult : p;
                    a_d        = {a_q[WIDTH-2:0], sub};
                    fin        = (op_q == OP_REMU) ? acc_d : a_d;
                end
                if (cnt_q == CNT_W'(ITERS - 1)) begin
                    state_d  = S_DONE;
                    result_d = fin;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (Start) begin
                    op_d  = op_in;
                    cnt_d = '0;
                    acc_d = '0;
                    a_d   = OpA;
                    b_d   = OpB;
                    if (op_in == OP_RSVD) begin
                        state_d  = S_DONE;
                        result_d = '0;
                    end else if (op_in == OP_DIVU && OpB == '0) begin
                        state_d  = S_DONE;
                        result_d = '1;
                    end else if (op_in == OP_REMU && OpB == '0) begin
                        state_d  = S_DONE;
                        result_d = OpA;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Operand/working registers need no reset: they are only observed in RUN.
    always_ff @(posedge clk) begin
        op_q  <= op_d;
        acc_q <= acc_d;
        a_q   <= a_d;
        b_q   <= b_d;
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Testbench for alu_muldiv_seq: vector table, random ops against a reference
// model, and hand sequences for ignored Start, mid-run reset and back-to-back ops.
module tb_alu_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] OpA, OpB;
    logic        Busy, Done;
    logic [31:0] Result, AluSrcA, AluSrcB, AluResult;
    logic [2:0]  AluControl;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    // External ALU, ADD/SUB subset.
    assign AluResult = (AluControl == 3'b001) ? (AluSrcA - AluSrcB) : (AluSrcA + AluSrcB);

    alu_muldiv_seq #(.WIDTH(32), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB),
        .Busy(Busy), .Done(Done), .Result(Result), .AluSrcA(AluSrcA),
        .AluSrcB(AluSrcB), .AluControl(AluControl), .AluResult(AluResult)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge in an IDLE or DONE cycle; returns at the negedge of the DONE cycle.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input string name);
        int          k;
        bit          bus_ok, drv_ok;
        logic [2:0]  ctl;
        logic [31:0] e;
        ctl   = (op == 2'b00) ? 3'b000 : 3'b001;
        Start = 1'b1; Op = op; OpA = a; OpB = b;
        exp_q.push_back(exp);
        @(negedge clk);
        Start  = 1'b0;
        k      = 1;
        bus_ok = 1'b1;
        drv_ok = 1'b1;
        while (!Done && k <= 40) begin
            if (Busy !== (lat > 1 && k <= 32)) bus_ok = 1'b0;
            if (Busy) begin
                if (AluControl !== ctl) drv_ok = 1'b0;
            end else if (AluSrcA !== 32'h0 || AluSrcB !== 32'h0 || AluControl !== 3'b000) begin
                drv_ok = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        if (Busy !== 1'b0) bus_ok = 1'b0;
        check({name, " latency"}, 32'(k), 32'(lat));
        e = exp_q.pop_front();
        check({name, " result"}, Result, e);
        check({name, " busy"}, {31'b0, bus_ok}, 32'd1);
        check({name, " alu_drive"}, {31'b0, drv_ok}, 32'd1);
    endtask

    initial begin
        int          k;
        bit          seen;
        logic [1:0]  op;
        logic [31:0] a, b, e;
        int          lat;

        vecs[0] = '{2'b00, 32'd7,         32'd6,         32'd42,        33, "mul_7x6"};
        vecs[1] = '{2'b00, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001,  33, "mul_ffxff"};
        vecs[2] = '{2'b00, 32'h00010000,  32'h00010000,  32'h00000000,  33, "mul_ovf"};
        vecs[3] = '{2'b01, 32'd100,       32'd7,         32'd14,        33, "divu_100_7"};
        vecs[4] = '{2'b10, 32'd100,       32'd7,         32'd2,         33, "remu_100_7"};
        vecs[5] = '{2'b01, 32'hFFFFFFFF,  32'h80000001,  32'h00000001,  33, "divu_hi"};
        vecs[6] = '{2'b10, 32'hFFFFFFFF,  32'h80000001,  32'h7FFFFFFE,  33, "remu_hi"};
        vecs[7] = '{2'b01, 32'd5,         32'd0,         32'hFFFFFFFF,  1,  "divu_by0"};
        vecs[8] = '{2'b10, 32'd1234,      32'd0,         32'd1234,      1,  "remu_by0"};
        vecs[9] = '{2'b11, 32'h55,        32'h66,        32'h00000000,  1,  "op_rsvd"};

        reset = 1'b1; Start = 1'b0; Op = 2'b00; OpA = '0; OpB = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, Busy}, 32'd0);
        check("rst_done", {31'b0, Done}, 32'd0);
        check("rst_result", Result, 32'd0);
        check("rst_srca", AluSrcA, 32'd0);
        check("rst_srcb", AluSrcB, 32'd0);
        check("rst_ctl", {29'b0, AluControl}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name);
            @(negedge clk);
            check({vecs[i].name, " done_one_cycle"}, {31'b0, Done}, 32'd0);
            check({vecs[i].name, " result_hold"}, Result, vecs[i].exp);
        end

        // Start during RUN cycle 5 must be ignored; Result holds the previous value (0 from op_rsvd).
        Start = 1'b1; Op = 2'b01; OpA = 32'd100; OpB = 32'd7;
        exp_q.push_back(32'd14);
        @(negedge clk);
        Start = 1'b0;
        k = 1;
        while (k < 5) begin @(negedge clk); k++; end
        Start = 1'b1; Op = 2'b00; OpA = 32'd3; OpB = 32'd3;
        @(negedge clk);
        Start = 1'b0;
        k++;
        check("ign_busy", {31'b0, Busy}, 32'd1);
        check("ign_result_held", Result, 32'd0);
        while (!Done && k <= 40) begin @(negedge clk); k++; end
        check("ign_latency", 32'(k), 32'd33);
        e = exp_q.pop_front();
        check("ign_result", Result, e);
        @(negedge clk);
        check("ign_no_extra_busy", {31'b0, Busy}, 32'd0);
        check("ign_no_extra_done", {31'b0, Done}, 32'd0);

        // Reset at RUN cycle 10 aborts without a Done pulse.
        Start = 1'b1; Op = 2'b00; OpA = 32'h12345; OpB = 32'h777;
        @(negedge clk);
        Start = 1'b0;
        k = 1;
        while (k < 10) begin @(negedge clk); k++; end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'b0, Busy}, 32'd0);
        check("abort_done", {31'b0, Done}, 32'd0);
        check("abort_result", Result, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            if (Done || Busy) seen = 1'b1;
            @(negedge clk);
        end
        check("abort_quiet", {31'b0, seen}, 32'd0);
        do_op(2'b00, 32'd3, 32'd4, 32'd12, 33, "mul_3x4");

        // Back-to-back: Start in the DONE cycle of each op.
        do_op(2'b00, 32'd7, 32'd6, 32'd42, 33, "b2b_mul");
        do_op(2'b01, 32'd100, 32'd7, 32'd14, 33, "b2b_divu");
        do_op(2'b01, 32'd5, 32'd0, 32'hFFFFFFFF, 1, "b2b_fast");
        do_op(2'b10, 32'd1000, 32'd9, 32'd1, 33, "b2b_remu");
        @(negedge clk);

        for (int i = 0; i < 1000; i++) begin
            op = 2'($urandom_range(0, 2));
            a  = $urandom;
            b  = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 15) == 0) b = 32'd0;
            case (op)
                2'b00:   e = a * b;
                2'b01:   e = (b == 0) ? 32'hFFFFFFFF : a / b;
                default: e = (b == 0) ? a : a % b;
            endcase
            lat = (op != 2'b00 && b == 0) ? 1 : 33;
            do_op(op, a, b, e, lat, $sformatf("rand%0d_op%0d_%h_%h", i, op, a, b));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
